// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared core definitions for the writeback arbiter: default FU and port counts,
// the writeback payload type, and a helper that sizes round-robin pointers.
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

  localparam int FU_NUM_DEF     = 6;
  localparam int WBPORT_NUM_DEF = 4;

  typedef struct packed {
    logic [7:0]  rob_idx;
    logic [4:0]  rd;
    logic [31:0] data;
  } valwbInfo_t;

  // Pointer width for an n-entry round-robin; never narrower than one bit.
  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_kofn_select.sv
// -----------------------------------------------------------------------------
// rr_kofn_select
// Combinational k-of-n round-robin selector. Scans requesters starting at rr_i
// (wrapping modulo FU_NUM) and hands the k-th requester found to port k, up to
// WBPORT_NUM grants.
//   req_i     : per-requester request
//   rr_i      : scan start index
//   grant_o   : per-port one-hot grant vector (all zero when the port is idle)
//   rr_next_o : index after the last granted requester, or rr_i if none granted
// -----------------------------------------------------------------------------
module rr_kofn_select
  import wb_port_arbiter_pkg::*;
#(
  parameter  int FU_NUM     = FU_NUM_DEF,
  parameter  int WBPORT_NUM = WBPORT_NUM_DEF,
  localparam int RR_W       = rr_width(FU_NUM)
) (
  input  logic [FU_NUM-1:0]                  req_i,
  input  logic [RR_W-1:0]                    rr_i,
  output logic [WBPORT_NUM-1:0][FU_NUM-1:0]  grant_o,
  output logic [RR_W-1:0]                    rr_next_o
);

  localparam logic [RR_W:0]   FU_NUM_W = (RR_W+1)'(FU_NUM);
  localparam logic [RR_W-1:0] LAST_IDX = RR_W'(FU_NUM - 1);

  always_comb begin
    logic [RR_W:0]   idx;
    logic [RR_W-1:0] last;
    logic            any;
    int              cnt;

    grant_o   = '0;
    rr_next_o = rr_i;
    idx       = '0;
    last      = '0;
    any       = 1'b0;
    cnt       = 0;

    for (int s = 0; s < FU_NUM; s++) begin
      // rr_i < FU_NUM and s < FU_NUM, so one conditional subtract wraps.
      idx = {1'b0, rr_i} + (RR_W+1)'(s);
      if (idx >= FU_NUM_W) idx = idx - FU_NUM_W;
      if (req_i[idx[RR_W-1:0]] && (cnt < WBPORT_NUM)) begin
        for (int k = 0; k < WBPORT_NUM; k++) begin
          if (cnt == k) grant_o[k][idx[RR_W-1:0]] = 1'b1;
        end
        cnt  = cnt + 1;
        last = idx[RR_W-1:0];
        any  = 1'b1;
      end
    end

    if (any) rr_next_o = (last == LAST_IDX) ? '0 : last + 1'b1;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Arbitrates FU_NUM integer FU writeback requests onto WBPORT_NUM register-file
// write ports. A request that loses arbitration is parked in a per-FU hold
// entry (stalling that FU) and, by the round-robin rule, wins the next cycle.
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active low
//   i_fu_vld/info  : per-FU writeback request and payload
//   o_fu_stall     : per-FU stall, high while that FU's hold entry is occupied
//   o_wb_vld/info  : registered write-port valid and payload, packed from port 0
//   o_conflict_cnt : saturating count of cycles with more requests than ports
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FU_NUM     = FU_NUM_DEF,
  parameter int WBPORT_NUM = WBPORT_NUM_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FU_NUM-1:0]                 i_fu_vld,
  input  valwbInfo_t [FU_NUM-1:0]           i_fu_info,
  output logic [FU_NUM-1:0]                 o_fu_stall,
  output logic [WBPORT_NUM-1:0]             o_wb_vld,
  output valwbInfo_t [WBPORT_NUM-1:0]       o_wb_info,
  output logic [31:0]                       o_conflict_cnt
);

  localparam int RR_W = rr_width(FU_NUM);

  logic [FU_NUM-1:0]                 hold_vld_q, hold_vld_d;
  valwbInfo_t [FU_NUM-1:0]           hold_info_q, src_info;
  logic [FU_NUM-1:0]                 req, granted, dup;
  logic [RR_W-1:0]                   rr_q, rr_d;
  logic [WBPORT_NUM-1:0][FU_NUM-1:0] grant;
  logic [WBPORT_NUM-1:0]             wb_vld_q, wb_vld_d;
  valwbInfo_t [WBPORT_NUM-1:0]       wb_info_q, wb_info_d;
  logic [31:0]                       conflict_cnt_q;
  logic                              conflict;

  rr_kofn_select #(
    .FU_NUM     (FU_NUM),
    .WBPORT_NUM (WBPORT_NUM)
  ) u_sel (
    .req_i     (req),
    .rr_i      (rr_q),
    .grant_o   (grant),
    .rr_next_o (rr_d)
  );

  always_comb begin
    // A held entry shadows any new input from the same FU.
    req = hold_vld_q | i_fu_vld;
    for (int i = 0; i < FU_NUM; i++)
      src_info[i] = hold_vld_q[i] ? hold_info_q[i] : i_fu_info[i];

    granted   = '0;
    dup       = '0;
    wb_vld_d  = '0;
    wb_info_d = '0;
    for (int k = 0; k < WBPORT_NUM; k++) begin
      wb_vld_d[k] = |grant[k];
      for (int i = 0; i < FU_NUM; i++) begin
        if (grant[k][i]) begin
          dup[i]       = dup[i] | granted[i];
          granted[i]   = 1'b1;
          wb_info_d[k] = src_info[i];
        end
      end
    end

    hold_vld_d = req & ~granted;
    conflict   = ($countones(req) > WBPORT_NUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld_q     <= '0;
      hold_info_q    <= '0;
      rr_q           <= '0;
      wb_vld_q       <= '0;
      wb_info_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      // Keep the parked payload; otherwise track the input so a capture is free.
      for (int i = 0; i < FU_NUM; i++)
        if (!hold_vld_q[i]) hold_info_q[i] <= i_fu_info[i];
      rr_q      <= rr_d;
      wb_vld_q  <= wb_vld_d;
      wb_info_q <= wb_info_d;
      if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF))
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign o_fu_stall     = hold_vld_q;
  assign o_wb_vld       = wb_vld_q;
  assign o_wb_info      = wb_info_q;
  assign o_conflict_cnt = conflict_cnt_q;

  // An FU must not present a new request while its previous one is parked.
  a_no_req_while_stalled: assert property (@(posedge clk) disable iff (!rst)
    (i_fu_vld & hold_vld_q) == '0);

  a_single_grant: assert property (@(posedge clk) disable iff (!rst)
    dup == '0);

  a_port_count: assert property (@(posedge clk) disable iff (!rst)
    $countones(wb_vld_q) <= WBPORT_NUM);

  // Valid ports form a run starting at port 0, i.e. the vector is 2^n-1.
  a_ports_contiguous: assert property (@(posedge clk) disable iff (!rst)
    (wb_vld_q & (wb_vld_q + 1'b1)) == '0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [5:0]           i_fu_vld;
  valwbInfo_t [5:0]     i_fu_info;
  logic [5:0]           o_fu_stall;
  logic [3:0]           o_wb_vld;
  valwbInfo_t [3:0]     o_wb_info;
  logic [31:0]          o_conflict_cnt;

  wb_port_arbiter #(.FU_NUM(6), .WBPORT_NUM(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_fu_vld       (i_fu_vld),
    .i_fu_info      (i_fu_info),
    .o_fu_stall     (o_fu_stall),
    .o_wb_vld       (o_wb_vld),
    .o_wb_info      (o_wb_info),
    .o_conflict_cnt (o_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int seq [6];

  typedef struct {
    int         fu;
    valwbInfo_t info;
    int         cyc;
  } sb_t;
  sb_t sbq [$];

  typedef struct {
    logic [5:0] vld;
    logic [3:0] exp_vld;
    int         exp_fu [4];
    logic [5:0] exp_stall;
    logic [31:0] exp_cnt;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int n, input logic [5:0] v, input logic [3:0] ev,
                         input int f0, input int f1, input int f2, input int f3,
                         input logic [5:0] st, input logic [31:0] cnt);
    vecs[n].vld       = v;
    vecs[n].exp_vld   = ev;
    vecs[n].exp_fu[0] = f0;
    vecs[n].exp_fu[1] = f1;
    vecs[n].exp_fu[2] = f2;
    vecs[n].exp_fu[3] = f3;
    vecs[n].exp_stall = st;
    vecs[n].exp_cnt   = cnt;
  endtask

  // Drive one cycle of requests; accepted requests go into the scoreboard.
  task automatic drive(input logic [5:0] v);
    i_fu_vld = v;
    for (int fu = 0; fu < 6; fu++) begin
      i_fu_info[fu].rob_idx = 8'($urandom);
      i_fu_info[fu].rd      = 5'($urandom);
      i_fu_info[fu].data    = $urandom;
      if (v[fu]) begin
        i_fu_info[fu].rob_idx = {3'(fu), 5'(seq[fu])};
        i_fu_info[fu].rd      = 5'(fu);
        if (!o_fu_stall[fu]) begin
          sb_t e;
          e.fu   = fu;
          e.info = i_fu_info[fu];
          e.cyc  = cyc;
          sbq.push_back(e);
          seq[fu]++;
        end
      end
    end
  endtask

  // Pop the oldest outstanding payload of whichever FU each valid port names.
  task automatic check_ports();
    for (int k = 0; k < 4; k++) begin
      if (o_wb_vld[k]) begin
        int fu;
        int hit;
        fu  = int'(o_wb_info[k].rob_idx[7:5]);
        hit = -1;
        for (int j = 0; j < sbq.size(); j++) begin
          if (sbq[j].fu == fu) begin
            hit = j;
            break;
          end
        end
        if (hit < 0) begin
          checks++;
          errors++;
          $display("FAIL sb_orphan port=%0d act_rob=%0h exp=<none outstanding>", k, o_wb_info[k].rob_idx);
        end else begin
          chk($sformatf("sb_payload_p%0d", k), 64'(o_wb_info[k]), 64'(sbq[hit].info));
          chk($sformatf("sb_age_le2_p%0d", k), 64'(cyc - sbq[hit].cyc <= 2), 64'd1);
          sbq.delete(hit);
        end
      end
    end
  endtask

  task automatic step(input logic [5:0] v);
    drive(v);
    @(posedge clk); #1;
    check_ports();
  endtask

  task automatic check_vec(input int n);
    chk($sformatf("v%0d_wb_vld", n), 64'(o_wb_vld), 64'(vecs[n].exp_vld));
    for (int k = 0; k < 4; k++)
      if (vecs[n].exp_vld[k])
        chk($sformatf("v%0d_port%0d_fu", n, k), 64'(o_wb_info[k].rob_idx[7:5]), 64'(vecs[n].exp_fu[k]));
    chk($sformatf("v%0d_stall", n), 64'(o_fu_stall), 64'(vecs[n].exp_stall));
    chk($sformatf("v%0d_cnt", n), 64'(o_conflict_cnt), 64'(vecs[n].exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 6; i++) seq[i] = 0;
    //          n  vld        wb_vld   ports            stall      cnt
    set_vec( 0, 6'b111111, 4'b1111,  0,  1,  2,  3, 6'b110000, 1);
    set_vec( 1, 6'b000000, 4'b0011,  4,  5, -1, -1, 6'b000000, 1);
    set_vec( 2, 6'b000101, 4'b0011,  0,  2, -1, -1, 6'b000000, 1);
    set_vec( 3, 6'b000000, 4'b0000, -1, -1, -1, -1, 6'b000000, 1);
    set_vec( 4, 6'b111111, 4'b1111,  3,  4,  5,  0, 6'b000110, 2);
    set_vec( 5, 6'b000000, 4'b0011,  1,  2, -1, -1, 6'b000000, 2);
    set_vec( 6, 6'b010000, 4'b0001,  4, -1, -1, -1, 6'b000000, 2);
    set_vec( 7, 6'b100011, 4'b0111,  5,  0,  1, -1, 6'b000000, 2);
    set_vec( 8, 6'b000101, 4'b0011,  2,  0, -1, -1, 6'b000000, 2);
    set_vec( 9, 6'b011110, 4'b1111,  1,  2,  3,  4, 6'b000000, 2);
    set_vec(10, 6'b111110, 4'b1111,  5,  1,  2,  3, 6'b010000, 3);
    set_vec(11, 6'b000001, 4'b0011,  4,  0, -1, -1, 6'b000000, 3);

    // Reset held with every FU requesting.
    rst       = 1'b0;
    i_fu_vld  = 6'b111111;
    i_fu_info = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_vld", 64'(o_wb_vld), 64'd0);
    chk("rst_stall", 64'(o_fu_stall), 64'd0);
    chk("rst_cnt", 64'(o_conflict_cnt), 64'd0);

    rst = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step(vecs[n].vld);
      check_vec(n);
    end

    // Reset mid-operation with two FUs parked.
    step(6'b111111);
    chk("mid_stall", 64'(o_fu_stall), 64'(6'b100001));
    chk("mid_cnt", 64'(o_conflict_cnt), 64'd4);
    drive(6'b000000);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_wb_vld", 64'(o_wb_vld), 64'd0);
    chk("midrst_stall", 64'(o_fu_stall), 64'd0);
    chk("midrst_cnt", 64'(o_conflict_cnt), 64'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    step(6'b100001);
    chk("post_rst_wb_vld", 64'(o_wb_vld), 64'(4'b0011));
    chk("post_rst_p0_fu", 64'(o_wb_info[0].rob_idx[7:5]), 64'd0);
    chk("post_rst_p1_fu", 64'(o_wb_info[1].rob_idx[7:5]), 64'd5);

    // Sustained overload: every unstalled FU requests every cycle.
    for (int c = 0; c < 100; c++) begin
      step(~o_fu_stall);
      chk("sus_wb_vld", 64'(o_wb_vld), 64'(4'b1111));
    end
    step(6'b000000);
    chk("sus_drained", 64'(sbq.size()), 64'd0);
    chk("sus_cnt", 64'(o_conflict_cnt), 64'd100);
    chk("sus_stall", 64'(o_fu_stall), 64'd0);

    // Counter saturation.
    force dut.conflict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt_q;
    step(6'b111111);
    chk("sat_first", 64'(o_conflict_cnt), 64'hFFFF_FFFF);
    step(~o_fu_stall);
    chk("sat_hold", 64'(o_conflict_cnt), 64'hFFFF_FFFF);
    step(6'b000000);
    step(6'b000000);
    chk("sat_drained", 64'(sbq.size()), 64'd0);
    chk("sat_hold_idle", 64'(o_conflict_cnt), 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
